// File: rtl/riscv_ctrl_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_ctrl_fsm_pkg                                           |
// | Description : Shared constants, state encoding and opcode classification   |
// |               for the multi-cycle RISC-V control sequencer.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package riscv_ctrl_fsm_pkg;

  // Major opcodes the sequencer understands
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  // ADDI x0,x0,0 - instruction register contents out of reset
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

  // Sequencer state encoding
  localparam int unsigned c_STATE_W = 3;
  localparam logic [c_STATE_W-1:0] c_ST_FETCH  = 3'd0;
  localparam logic [c_STATE_W-1:0] c_ST_DECODE = 3'd1;
  localparam logic [c_STATE_W-1:0] c_ST_EXEC   = 3'd2;
  localparam logic [c_STATE_W-1:0] c_ST_WB     = 3'd3;
  localparam logic [c_STATE_W-1:0] c_ST_HALT   = 3'd4;

  typedef enum logic [c_STATE_W-1:0] {
    ST_FETCH  = c_ST_FETCH,
    ST_DECODE = c_ST_DECODE,
    ST_EXEC   = c_ST_EXEC,
    ST_WB     = c_ST_WB,
    ST_HALT   = c_ST_HALT
  } ctrl_state_e;

  // Instruction field bit ranges
  localparam int unsigned c_OPC_LSB = 0;
  localparam int unsigned c_OPC_MSB = 6;
  localparam int unsigned c_RD_LSB  = 7;
  localparam int unsigned c_RD_MSB  = 11;
  localparam int unsigned c_F3_LSB  = 12;
  localparam int unsigned c_F3_MSB  = 14;
  localparam int unsigned c_RS1_LSB = 15;
  localparam int unsigned c_RS1_MSB = 19;
  localparam int unsigned c_RS2_LSB = 20;
  localparam int unsigned c_RS2_MSB = 24;
  localparam int unsigned c_F7_LSB  = 25;
  localparam int unsigned c_F7_MSB  = 31;

  // What the decode stage does with an opcode
  typedef enum logic [1:0] {
    OPC_CLS_ALU     = 2'd0,
    OPC_CLS_SYSTEM  = 2'd1,
    OPC_CLS_ILLEGAL = 2'd2
  } opc_class_e;

  function automatic opc_class_e classify_opcode(input logic [6:0] opc);
    opc_class_e cls;
    case (opc)
      c_OPC_OP, c_OPC_OP_IMM: cls = OPC_CLS_ALU;
      c_OPC_SYSTEM:           cls = OPC_CLS_SYSTEM;
      default:                cls = OPC_CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_ctrl_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_ctrl_fsm_if                                            |
// | Description : Instruction-memory handshake, decoded fields and ALU /       |
// |               register-file control bundle of the control sequencer.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface riscv_ctrl_fsm_if #(
  parameter int unsigned WIDTH = 32
);

  // Instruction memory handshake
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_valid;
  logic [31:0]      imem_rdata;

  // Program counter and decoded instruction fields
  logic [WIDTH-1:0] pc;
  logic [6:0]       opcode;
  logic [4:0]       RD;
  logic [2:0]       Funct3;
  logic [4:0]       RS1;
  logic [4:0]       RS2;
  logic [6:0]       Funct7;

  // ALU engine / register file control and core status
  logic             alu_start;
  logic             alu_done;
  logic             rf_we;
  logic             illegal;
  logic             halted;

  // The sequencer side
  modport master (
    output imem_req, imem_addr, pc, opcode, RD, Funct3, RS1, RS2, Funct7,
    output alu_start, rf_we, illegal, halted,
    input  imem_valid, imem_rdata, alu_done
  );

  // Memory / ALU / register-file side
  modport slave (
    input  imem_req, imem_addr, pc, opcode, RD, Funct3, RS1, RS2, Funct7,
    input  alu_start, rf_we, illegal, halted,
    output imem_valid, imem_rdata, alu_done
  );

endinterface
`default_nettype wire

// File: rtl/riscv_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_ctrl_fsm                                               |
// | Description : Multi-cycle fetch/decode/execute/writeback sequencer. Owns   |
// |               the PC, fetches over a req/valid handshake, latches the      |
// |               instruction, starts the ALU and gates the register write.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riscv_ctrl_fsm
  import riscv_ctrl_fsm_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      ALU_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  riscv_ctrl_fsm_if.master bus
);

  // The PC is kept as a word index so its two low bits are zero by construction
  localparam int unsigned          c_PCW          = WIDTH - 2;
  localparam logic [c_PCW-1:0]     c_PC_WORD_RST  = RESET_PC[WIDTH-1:2];
  localparam logic [c_PCW-1:0]     c_PC_WORD_ONE  = {{(c_PCW-1){1'b0}}, 1'b1};
  localparam logic [3:0]           c_ALU_TIMEOUT  = 4'(ALU_TIMEOUT);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [31:0]      r_ir;
  logic [c_PCW-1:0] r_pc_word;
  logic [3:0]       r_exec_cnt;

  logic             r_imem_req;
  logic             r_alu_start;
  logic             r_rf_we;
  logic             r_illegal;
  logic             r_halted;

  logic             w_latch_ir;
  logic             w_pc_adv;
  logic             w_alu_start_nxt;
  logic             w_rf_we_nxt;
  logic             w_illegal_nxt;
  logic             w_rd_nonzero;
  opc_class_e       w_cls;

  assign w_rd_nonzero = (r_ir[c_RD_MSB:c_RD_LSB] != 5'd0);
  assign w_cls        = classify_opcode(r_ir[c_OPC_MSB:c_OPC_LSB]);

  // Next-state and next-pulse decisions; fetch is accepted only while req is up
  always_comb begin
    w_state_nxt     = r_state;
    w_latch_ir      = 1'b0;
    w_pc_adv        = 1'b0;
    w_alu_start_nxt = 1'b0;
    w_rf_we_nxt     = 1'b0;
    w_illegal_nxt   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (r_imem_req && bus.imem_valid) begin
          w_latch_ir  = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_cls)
          OPC_CLS_ALU: begin
            w_alu_start_nxt = 1'b1;
            w_state_nxt     = ST_EXEC;
          end
          OPC_CLS_SYSTEM: begin
            w_state_nxt = ST_HALT;
          end
          default: begin
            w_illegal_nxt = 1'b1;
            w_pc_adv      = 1'b1;
            w_state_nxt   = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        // A completion arriving on the timeout cycle still counts
        if (bus.alu_done) begin
          w_rf_we_nxt = w_rd_nonzero;
          w_state_nxt = ST_WB;
        end else if (r_exec_cnt == c_ALU_TIMEOUT) begin
          w_illegal_nxt = 1'b1;
          w_pc_adv      = 1'b1;
          w_state_nxt   = ST_FETCH;
        end
      end
      ST_WB: begin
        w_pc_adv    = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction register and program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= c_NOP_INSTR;
      r_pc_word <= c_PC_WORD_RST;
    end else begin
      if (w_latch_ir) begin
        r_ir <= bus.imem_rdata;
      end
      if (w_pc_adv) begin
        r_pc_word <= r_pc_word + c_PC_WORD_ONE;
      end
    end
  end

  // Cycles spent in EXEC, restarting from zero on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exec_cnt <= 4'd0;
    end else if (r_state == ST_EXEC) begin
      r_exec_cnt <= r_exec_cnt + 4'd1;
    end else begin
      r_exec_cnt <= 4'd0;
    end
  end

  // Registered control outputs, all derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imem_req  <= 1'b0;
      r_alu_start <= 1'b0;
      r_rf_we     <= 1'b0;
      r_illegal   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_imem_req  <= (w_state_nxt == ST_FETCH);
      r_alu_start <= w_alu_start_nxt;
      r_rf_we     <= w_rf_we_nxt;
      r_illegal   <= w_illegal_nxt;
      r_halted    <= (w_state_nxt == ST_HALT);
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = {r_pc_word, 2'b00};
  assign bus.pc        = {r_pc_word, 2'b00};
  assign bus.opcode    = r_ir[c_OPC_MSB:c_OPC_LSB];
  assign bus.RD        = r_ir[c_RD_MSB:c_RD_LSB];
  assign bus.Funct3    = r_ir[c_F3_MSB:c_F3_LSB];
  assign bus.RS1       = r_ir[c_RS1_MSB:c_RS1_LSB];
  assign bus.RS2       = r_ir[c_RS2_MSB:c_RS2_LSB];
  assign bus.Funct7    = r_ir[c_F7_MSB:c_F7_LSB];
  assign bus.alu_start = r_alu_start;
  assign bus.rf_we     = r_rf_we;
  assign bus.illegal   = r_illegal;
  assign bus.halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_riscv_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riscv_ctrl_fsm                                            |
// | Description : Self-checking bench for riscv_ctrl_fsm: reacting memory and  |
// |               ALU models plus a per-instruction reference of latency,      |
// |               pulses, fields and PC.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_riscv_ctrl_fsm;

  localparam int unsigned c_WIDTH   = 32;
  localparam int          c_TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  riscv_ctrl_fsm_if #(.WIDTH(c_WIDTH)) bus ();

  riscv_ctrl_fsm #(
    .WIDTH       (c_WIDTH),
    .RESET_PC    (32'h0000_0000),
    .ALU_TIMEOUT (c_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc     = 32'h0;
  int          alu_rem  = -1;   // cycles until the ALU model answers, -1 = idle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.alu_done   = 1'b0;
    alu_rem        = -1;
  endtask

  // ALU model: answers 'alu_rem' cycles after the start pulse, noise while fetching
  task automatic alu_drive(input logic noise);
    if (alu_rem == 0) begin
      bus.alu_done = 1'b1;
      alu_rem      = -1;
    end else begin
      if (alu_rem > 0) alu_rem--;
      bus.alu_done = (alu_rem < 0 && bus.imem_req) ? noise : 1'b0;
    end
  endtask

  // Run one instruction from its first fetch cycle to the next fetch (or halt).
  // vd: cycles valid is withheld after req; ad: ALU answer delay, <0 = never.
  task automatic run_instr(input logic [31:0] instr, input int vd, input int ad);
    logic [6:0]  opc;
    logic [31:0] noise;
    bit          is_alu, is_sys, timed_out, acc, ended, halt_seen;
    int          exp_lat, exp_f, cyc, fcnt, n_start, n_we, n_ill;
    opc       = instr[6:0];
    is_alu    = (opc == 7'h33) || (opc == 7'h13);
    is_sys    = (opc == 7'h73);
    timed_out = is_alu && (ad < 0 || ad > c_TIMEOUT);
    exp_f     = vd + 1;
    if (!is_alu)        exp_lat = exp_f + 1;
    else if (timed_out) exp_lat = exp_f + 1 + c_TIMEOUT + 1;
    else                exp_lat = exp_f + 1 + (ad + 1) + 1;
    acc = 0; ended = 0; halt_seen = 0;
    cyc = 0; fcnt = 0; n_start = 0; n_we = 0; n_ill = 0;
    chk("fetch_req_up", {31'b0, bus.imem_req}, 32'd1);
    while (!ended && cyc < 80) begin
      if (cyc > 0 && acc && bus.imem_req) begin
        n_ill += int'(bus.illegal);
        ended = 1;
      end else if (bus.halted) begin
        halt_seen = 1;
        ended     = 1;
      end else begin
        if (bus.imem_req) begin
          fcnt++;
          chk("fetch_addr", bus.imem_addr, m_pc);
        end
        n_start += int'(bus.alu_start);
        n_we    += int'(bus.rf_we);
        if (cyc > 0) n_ill += int'(bus.illegal);
        noise = $urandom();
        if (bus.imem_req && !acc && fcnt - 1 == vd) begin
          bus.imem_valid = 1'b1;
          bus.imem_rdata = instr;
          acc            = 1;
        end else if (bus.imem_req) begin
          bus.imem_valid = 1'b0;
          bus.imem_rdata = noise;
        end else begin
          bus.imem_valid = noise[0];
          bus.imem_rdata = noise;
        end
        if (bus.alu_start) alu_rem = ad;
        alu_drive(noise[1]);
        @(negedge clk);
        cyc++;
      end
    end
    if (is_sys) begin
      chk("halt_seen", {31'b0, halt_seen}, 32'd1);
      chk("halt_latency", cyc, exp_f + 1);
      chk("halt_pc", bus.pc, m_pc);
    end else begin
      chk("instr_end", {31'b0, ended}, 32'd1);
      chk("latency", cyc, exp_lat);
      m_pc = m_pc + 32'd4;
      chk("pc_next", bus.pc, m_pc);
    end
    chk("fetch_cycles", fcnt, exp_f);
    chk("opcode", {25'b0, bus.opcode}, {25'b0, instr[6:0]});
    chk("rd",     {27'b0, bus.RD},     {27'b0, instr[11:7]});
    chk("funct3", {29'b0, bus.Funct3}, {29'b0, instr[14:12]});
    chk("rs1",    {27'b0, bus.RS1},    {27'b0, instr[19:15]});
    chk("rs2",    {27'b0, bus.RS2},    {27'b0, instr[24:20]});
    chk("funct7", {25'b0, bus.Funct7}, {25'b0, instr[31:25]});
    chk("alu_start_cnt", n_start, is_alu ? 1 : 0);
    chk("rf_we_cnt", n_we, (is_alu && !timed_out && instr[11:7] != 5'd0) ? 1 : 0);
    chk("illegal_cnt", n_ill, ((!is_alu && !is_sys) || timed_out) ? 1 : 0);
  endtask

  // Asynchronous reset asserted between edges, held 3 cycles, then released
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_async_pc", bus.pc, 32'h0);
    chk("rst_async_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_async_opcode", {25'b0, bus.opcode}, 32'h13);
    repeat (3) begin
      @(negedge clk);
      chk("rst_rf_we", {31'b0, bus.rf_we}, 32'd0);
      chk("rst_halted", {31'b0, bus.halted}, 32'd0);
      chk("rst_alu_start", {31'b0, bus.alu_start}, 32'd0);
      chk("rst_illegal", {31'b0, bus.illegal}, 32'd0);
    end
    rst_n = 1'b1;
    m_pc  = 32'h0;
    for (int i = 0; i < 4 && !bus.imem_req; i++) @(negedge clk);
    chk("req_after_rst", {31'b0, bus.imem_req}, 32'd1);
    chk("pc_after_rst", bus.pc, 32'h0);
    chk("halted_after_rst", {31'b0, bus.halted}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    int          sel, vd, ad, k;
    drive_idle();
    // Reset state and release
    repeat (3) @(negedge clk);
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_req", {31'b0, bus.imem_req}, 32'd0);
    chk("reset_rf_we", {31'b0, bus.rf_we}, 32'd0);
    chk("reset_halted", {31'b0, bus.halted}, 32'd0);
    chk("reset_ir", {25'b0, bus.opcode}, 32'h13);
    rst_n = 1'b1;
    for (int i = 0; i < 4 && !bus.imem_req; i++) @(negedge clk);
    chk("req_after_release", {31'b0, bus.imem_req}, 32'd1);

    // Directed instructions
    run_instr(32'h002081B3, 0, 0);   // ADD x3,x1,x2, minimum latency
    run_instr(32'h00500013, 0, 1);   // ADDI x0,x0,5: no register write
    run_instr(32'h002081B3, 3, 0);   // slow memory
    run_instr(32'h00000083, 0, 0);   // load opcode: illegal
    run_instr(32'h002081B3, 0, -1);  // ALU never answers: timeout
    run_instr(32'h002081B3, 1, 15);  // done on the timeout cycle wins
    run_instr(32'h002081B3, 0, 16);  // done one cycle late: timeout, late done ignored

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      r   = $urandom();
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      opc = 7'h33;
      else if (sel < 7) opc = 7'h13;
      else begin
        opc = 7'($urandom_range(0, 127));
        while (opc == 7'h33 || opc == 7'h13 || opc == 7'h73) opc = 7'($urandom_range(0, 127));
      end
      vd = int'($urandom_range(0, 3));
      k  = int'($urandom_range(0, 9));
      ad = (k < 7) ? int'($urandom_range(0, 4)) : (k == 7) ? 15 : (k == 8) ? 16 : -1;
      run_instr({r[31:7], opc}, vd, ad);
    end

    // Reset in the middle of EXEC: fetch an ADD and let it sit in EXEC
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h002081B3;
    bus.alu_done   = 1'b0;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_start", {31'b0, bus.alu_start}, 32'd1);
    @(negedge clk);
    do_reset();
    run_instr(32'h002081B3, 0, 0);

    // ECALL halts; memory and ALU activity afterwards is ignored
    run_instr(32'h00000073, 0, 0);
    repeat (10) begin
      r              = $urandom();
      bus.imem_valid = r[0];
      bus.imem_rdata = r;
      bus.alu_done   = r[1];
      @(negedge clk);
      chk("halt_level", {31'b0, bus.halted}, 32'd1);
      chk("halt_req", {31'b0, bus.imem_req}, 32'd0);
      chk("halt_rf_we", {31'b0, bus.rf_we}, 32'd0);
      chk("halt_pc_hold", bus.pc, m_pc);
    end
    do_reset();
    run_instr(32'h00A00093, 0, 2);   // ADDI x1,x0,10 after leaving HALT

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
